axis_pattern_generator: RTL and testbench
=========================================

Name: axis_pattern_generator

Overview:
AXI4-Stream master that generates periodic signed test waveforms (sawtooth, triangle, square) of period 2^log_count samples, scaled by a left shift. It drives the S_AXIS input of axis_extremum_finder and other stream consumers during bring-up and regression, replacing the ADC path. Full tready backpressure is honoured, and tlast marks the final sample of each period.

Parameters:
AXIS_TDATA_WIDTH, 32, stream data width in bits, two's complement samples.

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
enable  in  1  level; high = generate, low = stop at the end of the current period
mode  in  2  0 sawtooth, 1 triangle, 2 square, 3 zero
log_count  in  5  period = 2^L samples
shift  in  3  left shift applied to each sample
M_AXIS_tdata  out  AXIS_TDATA_WIDTH  sample
M_AXIS_tvalid  out  1  sample valid
M_AXIS_tready  in  1  consumer ready
M_AXIS_tlast  out  1  last sample of period
period_count  out  32  completed periods, wraps at 2^32

Behaviour:
- Reset is asynchronous and active-low on aresetn, and applies immediately, including mid-transfer.
  - Outputs on reset: tvalid=0, tdata=0, tlast=0, period_count=0.
  - Internal state on reset: state=IDLE, phase=0.
- Effective length L = clamp(log_count, 1, 30). Half period h = 2^(L-1).
- Phase counter p runs 0..2^L-1. It advances only on a handshake (tvalid && tready) and wraps to 0 after 2^L-1.
- Sample s, signed, computed at full width:
  - mode 0 (sawtooth): s = p - h.
  - mode 1 (triangle): t = (p < h) ? p : (2^L-1-p), then s = 2t - h.
  - mode 2 (square): s = (p < h) ? h : -h.
  - mode 3: s = 0.
- tdata = s << shift, truncated to AXIS_TDATA_WIDTH (two's complement wrap, no saturation).
- tlast = 1 exactly when p = 2^L-1.
- Configuration latch:
  - mode, log_count and shift are latched when a period starts, i.e. when the p=0 sample is loaded.
  - Changes made mid-period take effect at the next period boundary.
- Output register:
  - tdata, tvalid and tlast are registered.
  - While tvalid && !tready, tdata and tlast hold stable.
  - tvalid never drops without a handshake, except on reset.
- State machine, states IDLE, RUN, DRAIN:
  - IDLE: tvalid=0. If enable=1, load the p=0 sample and go to RUN; tvalid=1 the cycle after enable is first sampled high (latency 1).
  - RUN, on handshake:
    - If tlast: increment period_count.
    - If tlast and enable=1: load the p=0 sample, stay in RUN, no bubble.
    - If tlast and enable=0: tvalid=0, go to IDLE.
    - If not tlast and enable=0: go to DRAIN.
    - Otherwise: load the next sample.
  - RUN without handshake: hold outputs.
  - DRAIN: continue sample generation as in RUN, ignoring enable. On the tlast handshake, increment period_count, set tvalid=0 and go to IDLE.
- Throughput: one sample per cycle with tready held at 1.
- Simultaneous events:
  - enable re-asserted during DRAIN does not cancel DRAIN; the block returns to IDLE, then restarts on the following cycle.
  - A tlast handshake and a config change in the same cycle: the new config applies to the period being loaded.

Test Plan:
- Sawtooth: mode=0, L=3, shift=0, tready=1, enable=1 -> tdata -4,-3,-2,-1,0,1,2,3 repeating; tlast on every 3; period_count=2 after 16 beats.
- Triangle: mode=1, L=3, shift=1 -> tdata -8,-4,0,4,4,0,-4,-8; tlast on the 8th beat.
- Backpressure: sawtooth L=3; tready=0 for 3 cycles while tdata=-2 -> tdata=-2 and tvalid=1 held throughout; the next accepted beat is -1; no sample lost or duplicated.
- Stop: enable deasserted after beat value -3 (L=3) -> beats continue through 3 with tlast; tvalid=0 the next cycle; period_count increments by 1.
- Config change: log_count 3->2 written mid-period -> current period completes with 8 samples; next period is -2,-1,0,1; square with L=2, shift=2 gives 8,8,-8,-8.
- Reset: aresetn low mid-period -> tvalid/tdata/tlast/period_count read 0 with no clock edge; after release with enable=1, the first beat is the p=0 sample (-4 for sawtooth L=3).

Source files
------------

// File: rtl/axis_pattern_generator.sv
// AXI4-Stream test-waveform source: sawtooth, triangle or square with period 2^L,
// a per-sample left shift, full tready backpressure, and tlast on each period's last beat.
module axis_pattern_generator #(
  parameter int AXIS_TDATA_WIDTH = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        enable,
  input  logic [1:0]                  mode,
  input  logic [4:0]                  log_count,
  input  logic [2:0]                  shift,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                        M_AXIS_tvalid,
  input  logic                        M_AXIS_tready,
  output logic                        M_AXIS_tlast,
  output logic [31:0]                 period_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [29:0] phase_q, phase_n, pmax_n;
  logic [1:0]  mode_q, cfg_mode;
  logic [4:0]  len_q, len_clamped, cfg_len;
  logic [2:0]  shift_q, cfg_shift;
  logic        handshake, load_first, load_next, stop;

  // Signed sample for phase p, computed wide and truncated after the shift.
  function automatic logic [AXIS_TDATA_WIDTH-1:0] gen_sample(
    input logic [29:0] p, input logic [1:0] m, input logic [4:0] l, input logic [2:0] sh);
    logic signed [63:0] h, pp, t, s, full;
    h  = 64'sd1 <<< (l - 5'd1);
    pp = signed'(64'(p));
    t  = (pp < h) ? pp : ((h <<< 1) - 64'sd1 - pp);
    case (m)
      2'd0:    s = pp - h;
      2'd1:    s = (t <<< 1) - h;
      2'd2:    s = (pp < h) ? h : -h;
      default: s = '0;
    endcase
    full = s <<< sh;
    return full[AXIS_TDATA_WIDTH-1:0];
  endfunction

  assign handshake   = M_AXIS_tvalid & M_AXIS_tready;
  assign len_clamped = (log_count == 5'd0) ? 5'd1 : (log_count > 5'd30) ? 5'd30 : log_count;

  // A new period samples the live configuration; later beats use the latched copy.
  assign cfg_mode  = load_first ? mode        : mode_q;
  assign cfg_len   = load_first ? len_clamped : len_q;
  assign cfg_shift = load_first ? shift       : shift_q;
  assign phase_n   = load_first ? '0 : phase_q + 30'd1;
  assign pmax_n    = 30'((31'd1 << cfg_len) - 31'd1);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load_first = 1'b0;
    load_next  = 1'b0;
    stop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          load_first = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (handshake) begin
          if (M_AXIS_tlast) begin
            if (enable) load_first = 1'b1;
            else begin
              stop    = 1'b1;
              state_d = IDLE;
            end
          end else begin
            load_next = 1'b1;
            if (!enable) state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (handshake) begin
          if (M_AXIS_tlast) begin
            stop    = 1'b1;
            state_d = IDLE;
          end else begin
            load_next = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      phase_q       <= '0;
      mode_q        <= '0;
      len_q         <= 5'd1;
      shift_q       <= '0;
      M_AXIS_tdata  <= '0;
      M_AXIS_tvalid <= 1'b0;
      M_AXIS_tlast  <= 1'b0;
      period_count  <= '0;
    end else begin
      if (load_first) begin
        mode_q  <= mode;
        len_q   <= len_clamped;
        shift_q <= shift;
      end
      if (load_first || load_next) begin
        phase_q       <= phase_n;
        M_AXIS_tdata  <= gen_sample(phase_n, cfg_mode, cfg_len, cfg_shift);
        M_AXIS_tlast  <= (phase_n == pmax_n);
        M_AXIS_tvalid <= 1'b1;
      end else if (stop) begin
        M_AXIS_tvalid <= 1'b0;
        M_AXIS_tlast  <= 1'b0;
      end
      if (handshake && M_AXIS_tlast) period_count <= period_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_axis_pattern_generator.sv
// Scoreboard bench for axis_pattern_generator: expected beats are queued per period
// from an arithmetic waveform model and popped by a monitor on every accepted beat.
module tb_axis_pattern_generator;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = '0;
  logic [4:0]  log_count = 5'd3;
  logic [2:0]  shift = '0;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready = 1'b1;
  logic        tlast;
  logic [31:0] period_count;

  typedef struct packed {logic [31:0] d; logic l;} beat_t;
  beat_t q[$];

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  int base   = 0;
  int rdy_mode = 0;
  int exp_pc = 0;

  axis_pattern_generator #(.AXIS_TDATA_WIDTH(32)) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .mode(mode),
    .log_count(log_count), .shift(shift), .M_AXIS_tdata(tdata),
    .M_AXIS_tvalid(tvalid), .M_AXIS_tready(tready), .M_AXIS_tlast(tlast),
    .period_count(period_count)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Waveform model: values straight from the period/half-period arithmetic.
  function automatic logic [31:0] ref_sample(input int md, input int lc, input int sh, input longint p);
    longint len, n, h, s;
    len = (lc < 1) ? 1 : (lc > 30) ? 30 : lc;
    n = longint'(1) << len;
    h = n / 2;
    case (md)
      0:       s = p - h;
      1:       s = (p < h) ? 2 * p - h : 2 * (n - 1 - p) - h;
      2:       s = (p < h) ? h : -h;
      default: s = 0;
    endcase
    s = s * (longint'(1) << sh);
    return s[31:0];
  endfunction

  task automatic push_one(input logic [31:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    q.push_back(b);
  endtask

  task automatic push_period(input int md, input int lc, input int sh);
    int len, n;
    len = (lc < 1) ? 1 : (lc > 30) ? 30 : lc;
    n = 1 << len;
    for (int p = 0; p < n; p++) push_one(ref_sample(md, lc, sh, p), p == n - 1);
    exp_pc++;
  endtask

  task automatic push_lit(input int v[8], input int n);
    for (int i = 0; i < n; i++) push_one(32'(v[i]), i == n - 1);
    exp_pc++;
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_beats(input int k);
    int cnt = 0;
    while ((beats - base) < k && cnt < 3000) begin
      tick();
      cnt++;
    end
    if ((beats - base) < k) chk("beat_timeout", 64'(beats - base), 64'(k));
  endtask

  task automatic wait_done(input string name);
    int cnt = 0;
    while (q.size() != 0 && cnt < 3000) begin
      tick();
      cnt++;
    end
    if (q.size() != 0) begin
      chk({name, "_drain_timeout"}, 64'(q.size()), 64'd0);
      q.delete();
    end
    @(negedge aclk);
    chk({name, "_idle_tvalid"}, 64'(tvalid), 64'd0);
    chk({name, "_period_count"}, 64'(period_count), 64'(exp_pc));
    tick();
  endtask

  task automatic start_test(input int md, input int lc, input int sh);
    mode = 2'(md);
    log_count = 5'(lc);
    shift = 3'(sh);
    base = beats;
  endtask

  // tready driver runs after stimulus updates within the same step.
  always @(posedge aclk) begin
    #2;
    case (rdy_mode)
      0:       tready = 1'b1;
      1:       tready = ($urandom_range(0, 3) != 0);
      default: tready = 1'b0;
    endcase
  end

  logic        stall = 1'b0;
  logic [31:0] hold_d = '0;
  logic        hold_l = 1'b0;

  always @(negedge aclk) begin
    if (!aresetn) stall = 1'b0;
    else begin
      if (stall) begin
        chk("hold_tvalid", 64'(tvalid), 64'd1);
        chk("hold_tdata", 64'(tdata), 64'(hold_d));
        chk("hold_tlast", 64'(tlast), 64'(hold_l));
      end
      if (tvalid && tready) begin
        beats++;
        if (q.size() == 0) chk("unexpected_beat", 64'(tdata), 64'hDEAD);
        else begin
          beat_t b;
          b = q.pop_front();
          chk("tdata", 64'(tdata), 64'(b.d));
          chk("tlast", 64'(tlast), 64'(b.l));
        end
      end
      stall  = tvalid && !tready;
      hold_d = tdata;
      hold_l = tlast;
    end
  end

  int saw[8] = '{-4, -3, -2, -1, 0, 1, 2, 3};
  int tri_v[8] = '{-8, -4, 0, 4, 4, 0, -4, -8};
  int sq[8] = '{8, 8, -8, -8, 0, 0, 0, 0};

  initial begin
    #1;
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tdata", 64'(tdata), 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_period_count", 64'(period_count), 64'd0);
    tick(); tick();
    aresetn = 1'b1;
    tick();

    // Sawtooth, two back-to-back periods, full throughput
    start_test(0, 3, 0);
    rdy_mode = 0;
    push_lit(saw, 8);
    push_lit(saw, 8);
    enable = 1'b1;
    wait_beats(11);
    enable = 1'b0;
    wait_done("saw");

    // Triangle with shift and random backpressure, stop requested early
    start_test(1, 3, 1);
    rdy_mode = 1;
    push_lit(tri_v, 8);
    enable = 1'b1;
    wait_beats(2);
    enable = 1'b0;
    wait_done("tri");

    // Held stall on the -2 sample
    start_test(0, 3, 0);
    rdy_mode = 0;
    push_lit(saw, 8);
    enable = 1'b1;
    wait_beats(2);
    rdy_mode = 2;
    tick(); tick(); tick(); tick();
    @(negedge aclk);
    chk("stall_tdata", 64'(tdata), 64'hFFFFFFFE);
    chk("stall_tvalid", 64'(tvalid), 64'd1);
    tick();
    rdy_mode = 0;
    enable = 1'b0;
    wait_done("stall");

    // Mid-period config change applies at the next boundary
    start_test(0, 3, 0);
    push_period(0, 3, 0);
    push_lit(sq, 4);
    enable = 1'b1;
    wait_beats(3);
    mode = 2'd2; log_count = 5'd2; shift = 3'd2;
    wait_beats(9);
    enable = 1'b0;
    wait_done("cfg");

    // Re-enable during DRAIN: period finishes, one idle cycle, then restart
    start_test(1, 3, 0);
    rdy_mode = 1;
    push_period(1, 3, 0);
    push_period(1, 3, 0);
    enable = 1'b1;
    wait_beats(3);
    enable = 1'b0;
    wait_beats(4);
    enable = 1'b1;
    wait_beats(8);
    @(negedge aclk);
    chk("drain_bubble_tvalid", 64'(tvalid), 64'd0);
    tick();
    wait_beats(10);
    enable = 1'b0;
    wait_done("redrain");

    // Randomised configs; the change may land on the tlast handshake itself
    for (int it = 0; it < 8; it++) begin
      int m1, l1, s1, m2, l2, s2, n1, n2;
      m1 = $urandom_range(0, 3); l1 = $urandom_range(0, 4); s1 = $urandom_range(0, 7);
      m2 = $urandom_range(0, 3); l2 = $urandom_range(0, 4); s2 = $urandom_range(0, 7);
      n1 = 1 << ((l1 < 1) ? 1 : l1);
      n2 = 1 << ((l2 < 1) ? 1 : l2);
      start_test(m1, l1, s1);
      rdy_mode = $urandom_range(0, 1);
      push_period(m1, l1, s1);
      push_period(m2, l2, s2);
      enable = 1'b1;
      wait_beats($urandom_range(1, n1 - 1));
      mode = 2'(m2); log_count = 5'(l2); shift = 3'(s2);
      wait_beats(n1 + $urandom_range(1, n2 - 1));
      enable = 1'b0;
      wait_done("rand");
    end

    // Clamp at L=30, then asynchronous reset mid-period
    start_test(0, 31, 3);
    rdy_mode = 0;
    for (int p = 0; p < 4; p++) push_one(ref_sample(0, 31, 3, p), 1'b0);
    enable = 1'b1;
    wait_beats(4);
    rdy_mode = 2;
    tick(); tick();
    #2;
    aresetn = 1'b0;
    enable = 1'b0;
    #1;
    chk("midrst_tvalid", 64'(tvalid), 64'd0);
    chk("midrst_tdata", 64'(tdata), 64'd0);
    chk("midrst_tlast", 64'(tlast), 64'd0);
    chk("midrst_period_count", 64'(period_count), 64'd0);
    chk("midrst_queue", 64'(q.size()), 64'd0);
    exp_pc = 0;
    tick(); tick();
    aresetn = 1'b1;
    tick();

    start_test(0, 3, 0);
    rdy_mode = 0;
    push_lit(saw, 8);
    enable = 1'b1;
    wait_beats(1);
    enable = 1'b0;
    wait_done("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got time %0t required finish earlier", $time);
    $fatal(1);
  end

endmodule
